// File: rtl/prim_clock_gate_ctrl_pkg.sv
// Shared types and elaboration helpers for the gated-clock enable sequencer.
package prim_clock_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        RUN  = 2'd2,
        IDLE = 2'd3
    } ctrl_state_e;

    function automatic int unsigned cnt_width(input int unsigned wake_cycles,
                                              input int unsigned idle_cycles);
        int unsigned m;
        m = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
        if (m < 32'd1) begin
            m = 32'd1;
        end
        return $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/prim_clock_gate_ctrl.sv
// Enable sequencer for one gated-clock domain: wakes on demand, acks once stable,
// and gates off after an idle hysteresis period. Runs on the free-running clock.
module prim_clock_gate_ctrl
    import prim_clock_gate_ctrl_pkg::*;
#(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned CntW       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              force_on_i,
    input  logic              gate_cnt_clr_i,
    output logic [NumReq-1:0] ack_o,
    output logic              en_o,
    output logic [1:0]        state_o,
    output logic [CntW-1:0]   gate_cnt_o
);

    localparam int unsigned   CW        = cnt_width(WakeCycles, IdleCycles);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0] WAKE_LOAD = (WakeCycles > 32'd0) ? CW'(WakeCycles - 32'd1) : CNT_ZERO;
    localparam logic [CW-1:0] IDLE_LOAD = (IdleCycles > 32'd0) ? CW'(IdleCycles - 32'd1) : CNT_ZERO;
    localparam logic [CntW-1:0] GATE_ONE = CntW'(32'd1);

    ctrl_state_e     state_q;
    logic [CW-1:0]   cnt_q;
    logic            en_q;
    logic [CntW-1:0] gate_cnt_q;
    logic            wake_s;
    logic            go_off_s;

    assign wake_s = (|req_i) | force_on_i;

    // Flags the cycles that take the FSM into OFF, i.e. the gate-off events.
    always_comb begin
        go_off_s = 1'b0;
        case (state_q)
            RUN: begin
                if (!wake_s && (IdleCycles == 32'd0)) begin
                    go_off_s = 1'b1;
                end else begin
                    go_off_s = 1'b0;
                end
            end
            IDLE: begin
                if (!wake_s && (cnt_q == CNT_ZERO)) begin
                    go_off_s = 1'b1;
                end else begin
                    go_off_s = 1'b0;
                end
            end
            default: go_off_s = 1'b0;
        endcase
    end

    // Sequencer FSM with the shared down-counter; en_q stays a bare flop output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
            cnt_q   <= CNT_ZERO;
            en_q    <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (wake_s) begin
                        en_q <= 1'b1;
                        if (WakeCycles == 32'd0) begin
                            state_q <= RUN;
                        end else begin
                            state_q <= WAKE;
                            cnt_q   <= WAKE_LOAD;
                        end
                    end
                end
                WAKE: begin
                    // Wake has no abort path: it always completes into RUN.
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RUN: begin
                    if (!wake_s) begin
                        if (IdleCycles == 32'd0) begin
                            state_q <= OFF;
                            en_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= IDLE_LOAD;
                        end
                    end
                end
                IDLE: begin
                    // A wake on the final idle cycle wins, so en_q never dips.
                    if (wake_s) begin
                        state_q <= RUN;
                    end else if (cnt_q == CNT_ZERO) begin
                        state_q <= OFF;
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= OFF;
                    cnt_q   <= CNT_ZERO;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    // Saturating gate-off event counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gate_cnt_q <= {CntW{1'b0}};
        end else if (gate_cnt_clr_i) begin
            gate_cnt_q <= {CntW{1'b0}};
        end else if (go_off_s && (gate_cnt_q != {CntW{1'b1}})) begin
            gate_cnt_q <= gate_cnt_q + GATE_ONE;
        end else begin
            gate_cnt_q <= gate_cnt_q;
        end
    end

    assign en_o       = en_q;
    assign state_o    = state_q;
    assign gate_cnt_o = gate_cnt_q;
    assign ack_o      = ((state_q == RUN) || (state_q == IDLE)) ? req_i : {NumReq{1'b0}};

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Directed bench: expectations are queued when stimulus is applied and popped
// when outputs are sampled, one millisecond-free step at a time.
module tb_prim_clock_gate_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic        force_on;
    logic        clr;
    logic [3:0]  ack;
    logic        en;
    logic [1:0]  state;
    logic [15:0] gate_cnt;

    logic [3:0]  req2;
    logic        force2;
    logic        clr2;
    logic [3:0]  ack2;
    logic        en2;
    logic [1:0]  state2;
    logic [3:0]  gate_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    prim_clock_gate_ctrl #(
        .NumReq(4), .WakeCycles(2), .IdleCycles(16), .CntW(16)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .force_on_i(force_on),
        .gate_cnt_clr_i(clr), .ack_o(ack), .en_o(en), .state_o(state),
        .gate_cnt_o(gate_cnt)
    );

    prim_clock_gate_ctrl #(
        .NumReq(4), .WakeCycles(0), .IdleCycles(0), .CntW(4)
    ) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .force_on_i(force2),
        .gate_cnt_clr_i(clr2), .ack_o(ack2), .en_o(en2), .state_o(state2),
        .gate_cnt_o(gate_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        v = 32'd0;
        case (sel)
            0: v = 32'(en);
            1: v = 32'(ack);
            2: v = 32'(state);
            3: v = 32'(gate_cnt);
            4: v = 32'(en2);
            5: v = 32'(ack2);
            6: v = 32'(state2);
            7: v = 32'(gate_cnt2);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_core(input string tag, input logic e_en, input logic [3:0] e_ack,
                             input logic [1:0] e_state);
        push_exp({tag, "_en"}, 0, 32'(e_en));
        push_exp({tag, "_ack"}, 1, 32'(e_ack));
        push_exp({tag, "_state"}, 2, 32'(e_state));
    endtask

    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'd0; force_on = 1'b0; clr = 1'b0;
        req2 = 4'd0; force2 = 1'b0; clr2 = 1'b0;
        step(3);
        rst_n = 1'b1;

        // 1. idle after reset release
        for (int i = 0; i < 100; i++) begin
            step(1);
            push_core("rst_idle", 1'b0, 4'd0, 2'd0);
            push_exp("rst_idle_gcnt", 3, 32'd0);
            chk();
        end

        // 2. basic wake / ack / gate-off latency
        req = 4'b0001;
        step(1);
        push_core("wake_t1", 1'b1, 4'd0, 2'd1); chk();
        step(1);
        push_core("wake_t2", 1'b1, 4'd0, 2'd1); chk();
        step(1);
        push_core("run_t3", 1'b1, 4'b0001, 2'd2); chk();
        step(7);
        req = 4'd0;
        step(16);
        push_core("idle_t26", 1'b1, 4'd0, 2'd3); chk();
        step(1);
        push_core("off_t27", 1'b0, 4'd0, 2'd0);
        push_exp("off_t27_gcnt", 3, 32'd1); chk();

        // 3. re-request on the last idle cycle
        req = 4'b0001;
        step(3);
        push_core("rerun", 1'b1, 4'b0001, 2'd2); chk();
        req = 4'd0;
        step(16);
        push_core("idle_cnt0", 1'b1, 4'd0, 2'd3); chk();
        req = 4'b0100;
        #1;
        push_core("reack_same", 1'b1, 4'b0100, 2'd3); chk();
        step(1);
        push_core("reack_run", 1'b1, 4'b0100, 2'd2);
        push_exp("reack_gcnt", 3, 32'd1); chk();
        req = 4'd0;
        step(17);
        push_core("reack_off", 1'b0, 4'd0, 2'd0);
        push_exp("reack_off_gcnt", 3, 32'd2); chk();

        // 4. force_on keeps the clock running without acks
        force_on = 1'b1;
        step(1);
        for (int i = 0; i < 200; i++) begin
            push_exp("force_en", 0, 32'd1);
            push_exp("force_ack", 1, 32'd0);
            chk();
            step(1);
        end
        force_on = 1'b0;
        step(16);
        push_core("force_idle", 1'b1, 4'd0, 2'd3); chk();
        step(1);
        push_core("force_off", 1'b0, 4'd0, 2'd0);
        push_exp("force_gcnt", 3, 32'd3); chk();

        // 5. async reset in WAKE and in RUN
        req = 4'b0001;
        step(1);
        push_core("pre_rst_wake", 1'b1, 4'd0, 2'd1); chk();
        rst_n = 1'b0;
        #1;
        push_core("arst_wake", 1'b0, 4'd0, 2'd0);
        push_exp("arst_wake_gcnt", 3, 32'd0); chk();
        rst_n = 1'b1;
        step(1);
        push_core("restart_wake", 1'b1, 4'd0, 2'd1); chk();
        step(2);
        push_core("restart_run", 1'b1, 4'b0001, 2'd2); chk();
        rst_n = 1'b0;
        #1;
        push_core("arst_run", 1'b0, 4'd0, 2'd0); chk();
        rst_n = 1'b1;
        req = 4'b0010;
        step(1);
        push_core("rst2_wake", 1'b1, 4'd0, 2'd1); chk();
        step(2);
        push_core("rst2_run", 1'b1, 4'b0010, 2'd2); chk();
        req = 4'd0;
        step(17);
        push_core("rst2_off", 1'b0, 4'd0, 2'd0);
        push_exp("rst2_gcnt", 3, 32'd1); chk();

        // 6. zero wake/idle latency, saturation and clear priority (CntW=4)
        req2 = 4'b1000;
        step(1);
        push_exp("z_en", 4, 32'd1);
        push_exp("z_ack", 5, 32'b1000);
        push_exp("z_state", 6, 32'd2); chk();
        req2 = 4'd0;
        step(1);
        push_exp("z_off_en", 4, 32'd0);
        push_exp("z_off_state", 6, 32'd0);
        push_exp("z_gcnt1", 7, 32'd1); chk();
        for (int i = 0; i < 20; i++) begin
            req2 = 4'b0001;
            step(1);
            req2 = 4'd0;
            step(1);
        end
        push_exp("sat_gcnt", 7, 32'hF);
        push_exp("sat_state", 6, 32'd0); chk();
        req2 = 4'b0001;
        step(1);
        push_exp("sat_hold_run", 7, 32'hF); chk();
        req2 = 4'd0;
        clr2 = 1'b1;
        step(1);
        clr2 = 1'b0;
        push_exp("clr_wins", 7, 32'd0);
        push_exp("clr_state", 6, 32'd0); chk();
        req2 = 4'b0001;
        step(1);
        req2 = 4'd0;
        step(1);
        push_exp("post_clr_inc", 7, 32'd1); chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
